ps2_kbd_fifo: RTL and testbench
===============================

Name: ps2_kbd_fifo

Overview:
- Parametrised successor to the bare PS/2 keyboard receiver.
- Deserialises PS/2 frames and checks start, stop and odd-parity bits.
- Buffers good scancodes in a first-word-fall-through (FWFT) FIFO of configurable depth.
- Tracks make/break state and counts distinct key presses.
- Feeds the seg display and the counter logic in top; sits between the board ps2_clk/ps2_data pins and consumers on the system clock.

Parameters:
- FIFO_DEPTH, 8, number of scancode entries; must be a power of 2, at least 2.
- CNT_W, 8, width of the key-press counter.
- TIMEOUT_CYC, 50000, idle clk cycles mid-frame before abort; used only with PS2_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- rd_en  input  1  pop FIFO head when valid=1.
- code  output  8  FIFO head scancode (FWFT); 0 when empty.
- valid  output  1  FIFO not empty.
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; a good frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start, stop or parity bit (or timeout).
- key_down  output  1  a key is currently held.
- last_code  output  8  most recent make code.
- press_cnt  output  CNT_W  distinct key presses; wraps.

Behaviour:
- Reset (rst=1 sampled at clk edge):
  - FIFO emptied: valid=0, count=0, code=0.
  - overflow=0, frame_err=0, key_down=0, last_code=0, press_cnt=0.
  - Bit counter=0; decoder state=IDLE.
  - Any partial frame is discarded.
- Synchroniser: ps2_clk passes through a 3-flop shift register. A falling edge is the cycle where the two oldest stages are 1 then 0.
- Receiver, on each detected falling edge:
  - Bits 0-9 (start, D0-D7 LSB first, parity): shift ps2_data into a 10-bit buffer; bit counter increments.
  - Bit 10 (stop): frame is good iff start=0, stop (ps2_data)=1, and XOR of D0-D7 and parity =1.
  - Bit counter returns to 0 after bit 10 regardless of outcome.
  - Bad frame: frame_err pulses for one cycle; nothing is written; the decoder is unaffected.
- FIFO write/read rules:
  - Good frame with FIFO not full: D7..D0 written one cycle after the stop edge.
  - Good frame with FIFO full: frame dropped; overflow set. Exception: if rd_en=1 in the same cycle, the pop and the write both occur, with no overflow.
  - rd_en with valid=1: head advances next cycle; count decrements.
  - rd_en with valid=0: ignored.
  - Simultaneous write and read (not full): count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow clears only on rst.
- Decoder FSM: states IDLE, BREAK. Advances on every good frame, even if the FIFO dropped it.
  - IDLE, code 0xF0: go to BREAK.
  - IDLE, code 0xE0: ignored; stay in IDLE.
  - IDLE, any other code: if key_down=0 or code differs from last_code, increment press_cnt (typematic repeats are not counted); then key_down=1, last_code=code.
  - BREAK, any code: if code equals last_code, key_down=0; go to IDLE. last_code is unchanged.
- press_cnt wraps from 2^CNT_W-1 to 0.
- Latency: stop-bit falling edge detected to valid/decoder update is 1 clk.

Optional Feature:
- Macro PS2_TIMEOUT_EN.
- Defined:
  - A cycle counter restarts on every falling edge.
  - If the bit counter is non-zero and TIMEOUT_CYC cycles pass with no edge, the bit counter resets to 0 and frame_err pulses once.
  - Nothing is written to the FIFO.
- Undefined:
  - No timeout logic.
  - A partial frame waits indefinitely; only rst clears it.

Test Plan:
- Make/break sequence: send 0x1C (valid parity), then 0xF0, then 0x1C.
  - After 0x1C: count=1, code=0x1C, key_down=1, last_code=0x1C, press_cnt=1.
  - After 0xF0 and 0x1C: count=3, key_down=0, press_cnt=1.
- Typematic repeat: send 0x1C three times, then 0x32.
  - Expect press_cnt=2, last_code=0x32.
- Bad parity: send 0x1C with the parity bit flipped.
  - Expect frame_err pulse of exactly 1 cycle, count=0, press_cnt=0.
- Overflow, FIFO_DEPTH=8: send 9 good frames with rd_en=0.
  - Expect count=8, overflow=1, code equal to the first byte.
  - Then pop 8: each pop gives bytes in order; valid=0 after the 8th.
- Reset mid-frame: assert rst after 5 bits, then send a full 0x2A.
  - Expect exactly one entry 0x2A and frame_err=0.
- With PS2_TIMEOUT_EN and TIMEOUT_CYC=100: send 4 bits, then idle 100 cycles.
  - Expect one frame_err pulse.
  - A following full 0x2A is accepted cleanly.

Source files
------------

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: 3-flop clock sync, frame check, FWFT scancode FIFO, make/break decoder.
// Latency: stop-bit edge detected -> valid/decoder update in 1 clk; rd_en with valid=0 is ignored.
// Backpressure: a good frame arriving with the FIFO full is dropped and sets sticky overflow. Optional macro PS2_TIMEOUT_EN.
module ps2_kbd_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    code,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          key_down,
    output logic [7:0]                    last_code,
    output logic [CNT_W-1:0]              press_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, BREAK} dec_state_t;

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    dec_state_t    state;

    logic       fall;
    logic       ps2_bit;
    logic       frame_ok;
    logic       good_stb;
    logic [7:0] rx_byte;
    logic       full;
    logic       do_rd;
    logic       do_wr;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign ps2_bit  = data_sync[1];
    // shreg[0] = start, shreg[8:1] = D7..D0, shreg[9] = parity; ps2_bit is the stop bit
    assign frame_ok = ~shreg[0] & ps2_bit & (^shreg[9:1]);
    assign good_stb = fall && (bit_cnt == 4'd10) && frame_ok;
    assign rx_byte  = shreg[8:1];
    assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign valid    = (fifo_cnt != '0);
    assign do_rd    = rd_en & valid;
    assign do_wr    = good_stb & (~full | do_rd);
    assign count    = fifo_cnt;
    assign code     = valid ? mem[rd_ptr] : 8'h00;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            frame_err <= 1'b0;
            if (fall) begin
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!frame_ok)
                        frame_err <= 1'b1;
                end else begin
                    shreg   <= {ps2_bit, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
`ifdef PS2_TIMEOUT_EN
            if (fall || bit_cnt == 4'd0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                bit_cnt   <= '0;
                frame_err <= 1'b1;
                idle_cnt  <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (do_rd && !do_wr)
                fifo_cnt <= fifo_cnt - 1'b1;
            if (good_stb && !do_wr)
                overflow <= 1'b1;
        end
    end

    // Decoder follows every good frame, including ones the FIFO had to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_down  <= 1'b0;
            last_code <= '0;
            press_cnt <= '0;
        end else if (good_stb) begin
            case (state)
                IDLE: begin
                    if (rx_byte == 8'hF0) begin
                        state <= BREAK;
                    end else if (rx_byte != 8'hE0) begin
                        if (!key_down || rx_byte != last_code)
                            press_cnt <= press_cnt + 1'b1;
                        key_down  <= 1'b1;
                        last_code <= rx_byte;
                    end
                end
                BREAK: begin
                    if (rx_byte == last_code)
                        key_down <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: table-driven make/break/overflow vectors, corner sequences, random frames vs a queue model.
module tb_ps2_kbd_fifo;
    localparam int DEPTH = 8;
    localparam int HALF  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] code;
    logic       valid;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;
    logic       key_down;
    logic [7:0] last_code;
    logic [7:0] press_cnt;

    ps2_kbd_fifo #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .code(code), .valid(valid), .count(count), .overflow(overflow), .frame_err(frame_err),
        .key_down(key_down), .last_code(last_code), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int err_cycles = 0;

    always @(negedge clk) if (frame_err === 1'b1) err_cycles++;

    // Reference model: scancode queue plus key state from the decoding rules
    logic [7:0] mq[$];
    bit         m_ovf, m_kd, m_brk;
    logic [7:0] m_last, m_press;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_kd = 0; m_brk = 0; m_last = 0; m_press = 0;
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1;
        if (m_brk) begin
            if (b == m_last) m_kd = 0;
            m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b != 8'hE0) begin
            if (!m_kd || b != m_last) m_press = m_press + 8'd1;
            m_kd = 1;
            m_last = b;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, int'(count), mq.size());
        chk({tag, " valid"}, int'(valid), int'(mq.size() != 0));
        chk({tag, " code"}, int'(code), (mq.size() != 0) ? int'(mq[0]) : 0);
        chk({tag, " overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, " key_down"}, int'(key_down), int'(m_kd));
        chk({tag, " last_code"}, int'(last_code), int'(m_last));
        chk({tag, " press_cnt"}, int'(press_cnt), int'(m_press));
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
        logic par;
        par = ~^b;
        if (kind == 1) par = ~par;
        return {(kind == 2) ? 1'b0 : 1'b1, par, b, (kind == 3) ? 1'b1 : 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk); ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        repeat (HALF) @(negedge clk);
    endtask

    // Raises rd_en for the single clk edge at which the stop bit is accepted
    task automatic send_frame_pop(input logic [7:0] b);
        logic [10:0] f;
        f = mk_frame(b, 0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk); ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    typedef struct {
        logic [7:0] b;
        int         kind;
        int         n;
        int         press;
        bit         kd;
        logic [7:0] last;
        bit         ovf;
        int         errs;
    } vec_t;

    vec_t vt[10];

    initial begin
        int e0;
        vt[0] = '{8'h1C, 0, 1, 1, 1, 8'h1C, 0, 0};
        vt[1] = '{8'hF0, 0, 2, 1, 1, 8'h1C, 0, 0};
        vt[2] = '{8'h1C, 0, 3, 1, 0, 8'h1C, 0, 0};
        vt[3] = '{8'h1C, 0, 4, 2, 1, 8'h1C, 0, 0};
        vt[4] = '{8'h1C, 0, 5, 2, 1, 8'h1C, 0, 0};
        vt[5] = '{8'h1C, 0, 6, 2, 1, 8'h1C, 0, 0};
        vt[6] = '{8'h32, 0, 7, 3, 1, 8'h32, 0, 0};
        vt[7] = '{8'h1C, 1, 7, 3, 1, 8'h32, 0, 1};
        vt[8] = '{8'hE0, 0, 8, 3, 1, 8'h32, 0, 0};
        vt[9] = '{8'h55, 0, 8, 4, 1, 8'h55, 1, 0};

        do_reset();
        chk("reset valid", int'(valid), 0);
        chk("reset count", int'(count), 0);
        chk("reset code", int'(code), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset key_down", int'(key_down), 0);
        chk("reset last_code", int'(last_code), 0);
        chk("reset press_cnt", int'(press_cnt), 0);

        for (int i = 0; i < 10; i++) begin
            e0 = err_cycles;
            send_bits(mk_frame(vt[i].b, vt[i].kind), 11);
            if (vt[i].kind == 0) model_frame(vt[i].b);
            chk($sformatf("vec%0d count", i), int'(count), vt[i].n);
            chk($sformatf("vec%0d head", i), int'(code), 8'h1C);
            chk($sformatf("vec%0d press_cnt", i), int'(press_cnt), vt[i].press);
            chk($sformatf("vec%0d key_down", i), int'(key_down), int'(vt[i].kd));
            chk($sformatf("vec%0d last_code", i), int'(last_code), int'(vt[i].last));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vt[i].ovf));
            chk($sformatf("vec%0d err_cycles", i), err_cycles - e0, vt[i].errs);
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d code", i), int'(code), int'(mq[0]));
            pop_one();
        end
        chk("drained valid", int'(valid), 0);
        chk("drained code", int'(code), 0);
        chk("drained count", int'(count), 0);

        // Bad parity alone from reset
        do_reset();
        e0 = err_cycles;
        send_bits(mk_frame(8'h1C, 1), 11);
        chk("badpar err_cycles", err_cycles - e0, 1);
        chk("badpar count", int'(count), 0);
        chk("badpar press_cnt", int'(press_cnt), 0);

        // Reset mid-frame discards the partial frame
        do_reset();
        send_bits(mk_frame(8'h3B, 0), 5);
        do_reset();
        e0 = err_cycles;
        send_bits(mk_frame(8'h2A, 0), 11);
        model_frame(8'h2A);
        chk("midrst err_cycles", err_cycles - e0, 0);
        check_model("midrst");

        // Full FIFO with a pop coinciding with the write: no overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_bits(mk_frame(8'(8'h10 + i), 0), 11);
            model_frame(8'(8'h10 + i));
        end
        send_frame_pop(8'h18);
        void'(mq.pop_front());
        model_frame(8'h18);
        check_model("fullpop");
        chk("fullpop head", int'(code), 8'h11);

`ifdef PS2_TIMEOUT_EN
        do_reset();
        e0 = err_cycles;
        send_bits(mk_frame(8'h77, 0), 4);
        repeat (100) @(negedge clk);
        chk("timeout err_cycles", err_cycles - e0, 1);
        e0 = err_cycles;
        send_bits(mk_frame(8'h2A, 0), 11);
        model_frame(8'h2A);
        chk("post-timeout err_cycles", err_cycles - e0, 0);
        check_model("post-timeout");
`endif

        // Random frames against the model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            logic [7:0] b;
            int kind, np;
            case ($urandom_range(0, 5))
                0: b = 8'h1C;
                1: b = 8'h32;
                2: b = 8'hF0;
                3: b = 8'hE0;
                4: b = 8'h5A;
                default: b = 8'($urandom);
            endcase
            kind = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            e0 = err_cycles;
            send_bits(mk_frame(b, kind), 11);
            if (kind == 0) model_frame(b);
            chk($sformatf("rnd%0d err_cycles", it), err_cycles - e0, (kind != 0) ? 1 : 0);
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) pop_one();
            check_model($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
